// File: rtl/mem_pkg.sv
// Shared constants and index helpers for the TOY main-memory responder.
package mem_pkg;
  localparam int MEM_AW     = 8;
  localparam int MEM_DW     = 16;
  localparam int MEM_RPORTS = 2;
  localparam int MEM_N      = MEM_RPORTS + 1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int MEM_IW = idx_w(MEM_N);
  typedef logic [MEM_IW-1:0] req_idx_t;
endpackage

// File: rtl/mem_if.sv
// Read-only and read/write memory port bundles between the core and mem_ctrl.
interface mem_rport #(
  parameter int AW = mem_pkg::MEM_AW,
  parameter int DW = mem_pkg::MEM_DW
);
  logic          val;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          rdy;

  modport master (output val, output addr, input data, input rdy);
  modport slave  (input val, input addr, output data, output rdy);
endinterface

interface mem_rwport #(
  parameter int AW = mem_pkg::MEM_AW,
  parameter int DW = mem_pkg::MEM_DW
);
  logic          val;
  logic          wen;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rdy;

  modport master (output val, output wen, output addr, output wdata, input rdata, input rdy);
  modport slave  (input val, input wen, input addr, input wdata, output rdata, output rdy);
endinterface

// File: rtl/mem_rr_arb.sv
// Combinational round-robin arbiter: first pending requestor at or after ptr, wrapping.
module mem_rr_arb
  import mem_pkg::*;
#(
  parameter int N = MEM_N,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_val
);

  int cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_val = 1'b0;
    cand    = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!gnt_val && req[cand]) begin
        gnt_val   = 1'b1;
        gnt_idx   = IW'(cand);
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Main-memory responder: round-robin serialises read ports and the load/store
// port onto one synchronous RAM; each grant completes with a one-cycle rdy.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int RPORTS = MEM_RPORTS,
  parameter int AW     = MEM_AW,
  parameter int DW     = MEM_DW
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  mem_rport.slave   r_intf [RPORTS],
  mem_rwport.slave  rw_intf
);

  localparam int N  = RPORTS + 1;
  localparam int IW = idx_w(N);
  localparam int RW = RPORTS;

  logic [N-1:0]  val;
  logic [AW-1:0] addr [N];
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_val;
  logic [AW-1:0] addr_sel;
  logic          we;

  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  rdy_q, rdy_d;
  logic [DW-1:0] data_q [N];
  logic [DW-1:0] data_d [N];

  logic [DW-1:0] mem [2**AW];

  for (genvar i = 0; i < RPORTS; i++) begin : g_rport
    assign val[i]         = r_intf[i].val;
    assign addr[i]        = r_intf[i].addr;
    assign r_intf[i].data = data_q[i];
    assign r_intf[i].rdy  = rdy_q[i];
  end

  assign val[RW]       = rw_intf.val;
  assign addr[RW]      = rw_intf.addr;
  assign rw_intf.rdata = data_q[RW];
  assign rw_intf.rdy   = rdy_q[RW];

  // A port in its completion cycle sits out arbitration, so a held val is not re-served.
  assign req = val & ~rdy_q;

  mem_rr_arb #(.N(N)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_val (gnt_val)
  );

  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) addr_sel = addr[i];
    end
  end

  assign we = gnt[RW] & rw_intf.wen;

  always_comb begin
    ptr_d  = ptr_q;
    rdy_d  = gnt;
    data_d = data_q;
    if (gnt_val) begin
      ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
    // Old contents are captured even on a write: read-before-write.
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) data_d[i] = mem[addr_sel];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      rdy_q <= '0;
      for (int i = 0; i < N; i++) data_q[i] <= '0;
    end else begin
      ptr_q  <= ptr_d;
      rdy_q  <= rdy_d;
      data_q <= data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) mem[addr_sel] <= rw_intf.wdata;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed scenarios plus randomized traffic against a memory model.
module tb_mem_ctrl;
  import mem_pkg::*;

  localparam int NR  = MEM_RPORTS;
  localparam int N   = NR + 1;
  localparam int RWP = NR;
  localparam int TMO = 4 * N;

  typedef struct packed {
    logic [15:0] d;
    logic        chk;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [N-1:0] tb_val   = '0;
  logic [7:0]   tb_addr [N];
  logic         tb_wen   = 1'b0;
  logic [15:0]  tb_wdata = '0;

  logic [N-1:0] obs_rdy;
  logic [15:0]  obs_data [N];

  exp_t         exp_q [N][$];
  int           age [N];
  exp_t         mon_e;
  logic [15:0]  ref_mem [256];
  bit           busy [N];
  logic [7:0]   busy_addr [N];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_rport  r_if [NR] ();
  mem_rwport rw_if ();

  for (genvar i = 0; i < NR; i++) begin : g_rp
    assign r_if[i].val  = tb_val[i];
    assign r_if[i].addr = tb_addr[i];
    assign obs_rdy[i]   = r_if[i].rdy;
    assign obs_data[i]  = r_if[i].data;
  end

  assign rw_if.val      = tb_val[RWP];
  assign rw_if.wen      = tb_wen;
  assign rw_if.addr     = tb_addr[RWP];
  assign rw_if.wdata    = tb_wdata;
  assign obs_rdy[RWP]   = rw_if.rdy;
  assign obs_data[RWP]  = rw_if.rdata;

  mem_ctrl #(.RPORTS(NR)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .r_intf  (r_if),
    .rw_intf (rw_if)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int p, input logic [15:0] d, input logic chk);
    exp_t e;
    e.d   = d;
    e.chk = chk;
    exp_q[p].push_back(e);
  endtask

  // Present a request; the model predicts the response from memory state at issue time.
  task automatic drive(input int p, input logic [7:0] a, input logic w, input logic [15:0] wd,
                       input logic chk);
    push_exp(p, ref_mem[a], chk);
    if (w) ref_mem[a] = wd;
    tb_addr[p] = a;
    if (p == RWP) begin
      tb_wen   = w;
      tb_wdata = wd;
    end
    tb_val[p] = 1'b1;
  endtask

  task automatic issue(input int p, input logic [7:0] a, input logic w, input logic [15:0] wd,
                       input logic chk);
    bit got;
    drive(p, a, w, wd, chk);
    got = 1'b0;
    for (int i = 0; i < TMO && !got; i++) begin
      step();
      got = obs_rdy[p];
    end
    check($sformatf("issue_done_p%0d", p), 32'(got), 32'd1);
    tb_val[p] = 1'b0;
    if (p == RWP) tb_wen = 1'b0;
  endtask

  function automatic bit any_busy();
    bit b;
    b = 1'b0;
    for (int p = 0; p < N; p++) b |= busy[p];
    return b;
  endfunction

  task automatic random_cycle(input bit issuing);
    logic [7:0] a;
    bit         conflict;
    logic       w;
    for (int p = 0; p < N; p++) begin
      if (busy[p] && obs_rdy[p]) busy[p] = 1'b0;
    end
    for (int p = 0; p < N; p++) begin
      if (!busy[p]) begin
        if (issuing && $urandom_range(0, 3) != 0) begin
          a = 8'($urandom_range(0, 254));
          for (int t = 0; t < 16; t++) begin
            conflict = 1'b0;
            for (int q = 0; q < N; q++) begin
              if (q != p && busy[q] && busy_addr[q] == a) conflict = 1'b1;
            end
            if (!conflict) break;
            a = 8'($urandom_range(0, 254));
          end
          w = (p == RWP) ? 1'($urandom_range(0, 1)) : 1'b0;
          drive(p, a, w, 16'($urandom), 1'b1);
          busy[p]      = 1'b1;
          busy_addr[p] = a;
        end else begin
          tb_val[p] = 1'b0;
          if (p == RWP) tb_wen = 1'b0;
        end
      end
    end
    step();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("rdy_at_most_one", 32'($countones(obs_rdy) > 1), 32'd0);
      for (int p = 0; p < N; p++) begin
        if (obs_rdy[p]) begin
          age[p] = 0;
          check($sformatf("rdy_has_request_p%0d", p), 32'(exp_q[p].size() != 0), 32'd1);
          if (exp_q[p].size() != 0) begin
            mon_e = exp_q[p].pop_front();
            if (mon_e.chk) check($sformatf("data_p%0d", p), 32'(obs_data[p]), 32'(mon_e.d));
          end
        end else if (exp_q[p].size() != 0) begin
          age[p]++;
          if (age[p] > TMO) begin
            check($sformatf("rdy_timeout_p%0d", p), 32'(age[p]), 32'(TMO));
            void'(exp_q[p].pop_front());
            age[p] = 0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] v;
    for (int p = 0; p < N; p++) begin
      tb_addr[p]   = '0;
      age[p]       = 0;
      busy[p]      = 1'b0;
      busy_addr[p] = '0;
    end

    // Reset then idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_rdy", 32'(obs_rdy), 32'd0);
      for (int p = 0; p < N; p++) check($sformatf("idle_data_p%0d", p), 32'(obs_data[p]), 32'd0);
    end
    step();

    // Program load through the rw port; old contents are unknown so not checked
    for (int a = 0; a < 255; a++) begin
      v = (a == 'h10) ? 16'h1234 : (a == 'h30) ? 16'h0000 : 16'($urandom);
      issue(RWP, 8'(a), 1'b1, v, 1'b0);
    end

    // Single read: rdy only in the cycle after val
    step();
    drive(0, 8'h10, 1'b0, 16'h0, 1'b1);
    check("single_c0_rdy", 32'(obs_rdy), 32'd0);
    step();
    check("single_c1_rdy", 32'(obs_rdy), 32'd1);
    check("single_c1_data", 32'(obs_data[0]), 32'h1234);
    tb_val[0] = 1'b0;
    step();
    check("single_c2_rdy", 32'(obs_rdy), 32'd0);

    // Write returns old data, then a read sees the new data
    issue(RWP, 8'h30, 1'b1, 16'hBEEF, 1'b1);
    check("wr_old_rdata", 32'(obs_data[RWP]), 32'h0000);
    issue(0, 8'h30, 1'b0, 16'h0, 1'b1);
    check("rd_after_wr", 32'(obs_data[0]), 32'hBEEF);

    // Exclusion: back-to-back requests on one port complete every other cycle
    step();
    drive(0, 8'h11, 1'b0, 16'h0, 1'b1);
    step();
    check("excl_c1_rdy", 32'(obs_rdy), 32'd1);
    drive(0, 8'h12, 1'b0, 16'h0, 1'b1);
    step();
    check("excl_c2_rdy", 32'(obs_rdy), 32'd0);
    step();
    check("excl_c3_rdy", 32'(obs_rdy), 32'd1);
    tb_val[0] = 1'b0;
    step();
    check("excl_c4_rdy", 32'(obs_rdy), 32'd0);

    // Round robin from reset with every port continuously valid
    rst_n = 1'b0;
    drive(0, 8'h05, 1'b0, 16'h0, 1'b1);
    drive(1, 8'h06, 1'b0, 16'h0, 1'b1);
    drive(RWP, 8'h20, 1'b0, 16'h0, 1'b1);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("rr_cycle%0d", i), 32'(obs_rdy), 32'(1 << (i % N)));
      for (int p = 0; p < N; p++) begin
        if (obs_rdy[p]) begin
          if (i < 6) push_exp(p, ref_mem[tb_addr[p]], 1'b1);
          else tb_val[p] = 1'b0;
        end
      end
    end
    step();
    check("rr_quiet", 32'(obs_rdy), 32'd0);

    // Reset in the cycle after a write grant: no rdy, but the write persists
    step();
    tb_addr[RWP]  = 8'h40;
    tb_wen        = 1'b1;
    tb_wdata      = 16'hCAFE;
    tb_val[RWP]   = 1'b1;
    ref_mem[8'h40] = 16'hCAFE;
    step();
    rst_n  = 1'b0;
    tb_val = '0;
    tb_wen = 1'b0;
    @(negedge clk);
    check("rst_rdy", 32'(obs_rdy), 32'd0);
    for (int p = 0; p < N; p++) check($sformatf("rst_data_p%0d", p), 32'(obs_data[p]), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    issue(1, 8'h40, 1'b0, 16'h0, 1'b1);
    check("rst_write_kept", 32'(obs_data[1]), 32'hCAFE);

    // Randomized concurrent traffic
    step();
    for (int c = 0; c < 400; c++) random_cycle(1'b1);
    for (int c = 0; c < 50 && any_busy(); c++) random_cycle(1'b0);
    check("drain_idle", 32'(any_busy()), 32'd0);
    repeat (3) step();
    begin
      int left;
      left = 0;
      for (int p = 0; p < N; p++) left += exp_q[p].size();
      check("queues_empty", 32'(left), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Shared main-memory responder for the TOY core: the slave end of the core's instruction-fetch read ports (`mem_rport`) and its load/store port (`mem_rwport`). It owns one 256 x 16 synchronous single-port RAM and serialises all requests onto it with a round-robin arbiter. Every accepted request completes with a one-cycle `rdy` pulse carrying read data.

## Interface
Parameters:
- `RPORTS`, default `MEM_RPORTS` (2): number of read-only slave ports.
- `AW`, default 8: address width. RAM depth is 2^AW.
- `DW`, default 16: word width.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `r_intf[0:RPORTS-1]`  `mem_rport.slave`  port array:
  - `val` in 1
  - `addr` in AW
  - `data` out DW
  - `rdy` out 1
- `rw_intf`  `mem_rwport.slave`:
  - `val` in 1
  - `wen` in 1
  - `addr` in AW
  - `wdata` in DW
  - `rdata` out DW
  - `rdy` out 1

## Operation
- Requestors are indexed 0..RPORTS-1 for the read ports and RPORTS for the rw port. There are N = RPORTS+1 requestors in total.
- Request rule: a requestor is pending in cycle c when `val`=1 and its `rdy`=0 in cycle c. A requestor whose `rdy` is high in cycle c is excluded from arbitration in c.
- Master rule: the master holds `val`, `addr`, `wen` and `wdata` stable from assertion until the cycle its `rdy`=1. That cycle completes the transfer.
- Arbiter:
  - Each cycle, exactly one pending requestor is granted, or none if nothing is pending.
  - Search starts at `ptr` and wraps modulo N.
  - On a grant to g, `ptr` <= (g+1) mod N. Otherwise `ptr` holds.
- RAM access in the grant cycle:
  - Read: the RAM is read at `addr`.
  - Write (`rw_intf.wen`=1): the RAM is written with `wdata` at the clock edge. `rdata` returns the old contents (read-before-write).
- Completion: in the cycle after a grant to g, the responder drives `rdy[g]`=1 for exactly one cycle. Data is driven on that port's `data`/`rdata`.
- Data outputs are registered per port. Each holds its value until that port's next completion.
- Ordering: accesses execute in grant order. A read granted after a write to the same address returns the new value.
- No address decoding. Address 0xFF (stdio) is never presented; the core's LSU intercepts it.
- Abandoned request (master drops `val` before `rdy`): if already granted, the completion still pulses and is ignored. If not yet granted, no access occurs.
- RAM contents are not reset. Program load uses the rw port.

## Timing
- Reset values:
  - every `rdy`: 0
  - every `data`/`rdata`: 0
  - `ptr`: 0
  - grant-pending register: empty
- Reset mid-operation: an in-flight grant is discarded and no `rdy` follows. A write already clocked into the RAM stays.
- Latency: minimum 1 cycle (val in cycle c with immediate grant gives `rdy` in c+1).
- Worst case with all requestors busy: N cycles from `val` to `rdy`.
- Throughput:
  - aggregate: 1 access per cycle
  - single port: 1 per 2 cycles, due to the exclusion rule
- `rdy` and data are combinational functions of registers only. There is no combinational path from any input to any output.
- At most one `rdy` is high in any cycle.

## Structure
- Package `mem_pkg` holds `AW`, `DW`, the default port count, and the requestor index type (`$clog2(N)` bits).
- Sub-module `mem_rr_arb` (parameter N):
  - inputs: `req[N]`, `ptr`
  - outputs: one-hot `gnt`, `gnt_idx`, `gnt_val`
  - purely combinational
  - `ptr` register lives in `mem_ctrl`
- RAM is an inferred array with one synchronous access per cycle. No reset on the array.

## Test plan
- Reset then idle: all `rdy`=0 and all data=0 for 10 cycles with every `val`=0.
- Single read:
  - preload 0x10=0x1234 via rw write
  - r_intf[0] `val` with `addr`=0x10 at cycle c
  - expect `rdy[0]`=1 and `data`=0x1234 at c+1 only
- Round robin:
  - r0, r1 and rw (read 0x20) all held valid continuously from reset
  - expected grant order: r0, r1, rw, r0, ...
  - expect each `rdy` pulse exactly 3 cycles apart per port
  - expect no cycle with two `rdy` high
- Write then read:
  - rw write 0x30=0xBEEF completes with `rdata`=old value 0x0000 (preloaded)
  - next r0 read 0x30 returns 0xBEEF
- Exclusion:
  - r0 keeps `val`=1 with `addr` 0x11 then 0x12 back-to-back, others idle
  - expect `rdy` at c+1 and c+3, never on consecutive cycles
- Reset mid-grant:
  - assert `rst_ni`=0 in the cycle after an rw write grant
  - expect no `rdy`
  - after release, a read of that address returns the written data
